// File: rtl/loop_recorder.sv
// Looper stage: records the processed stream into an SRAM region, then plays it back
// repeatedly, saturating-mixed with the live stream. One SRAM access per accepted sample.
module loop_recorder #(
  parameter logic [19:0] BASE_ADDR = 20'h80000,
  parameter logic [19:0] MAX_LEN   = 20'h80000
) (
  input  logic        i_AUD_BCLK,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  input  logic        i_rec,
  input  logic        i_play,
  output logic        o_sram_req,
  input  logic        i_sram_gnt,
  output logic [19:0] o_sram_addr,
  output logic        o_sram_we_n,
  output logic [15:0] o_sram_wdata,
  input  logic [15:0] i_sram_rdata,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic [1:0]  o_mode,
  output logic [19:0] o_loop_len,
  output logic        o_overrun
);

  typedef enum logic [1:0] {SeqIdle, SeqReq, SeqAcc, SeqByp} seq_e;
  typedef enum logic [1:0] {ModeEmpty = 2'd0, ModeRecord = 2'd1, ModeLoop = 2'd2} mode_e;
  typedef enum logic [1:0] {OpByp, OpWr, OpRd} op_e;

  seq_e        seq_q, seq_d;
  logic        pad_q, pad_d;
  mode_e       mode_q, mode_nxt_q, mode_nxt_d;
  logic [19:0] len_q, len_nxt_q, len_nxt_d;
  logic [19:0] wr_q, wr_nxt_q, wr_nxt_d;
  logic [19:0] rd_q, rd_nxt_q, rd_nxt_d;
  logic [19:0] addr_q, addr_d;
  op_e         op_q, op_d;
  logic [15:0] samp_q;
  logic [15:0] data_q;
  logic        valid_q;
  logic        overrun_q;

  logic        accept;
  logic        done;
  logic        acc_wr;
  logic [16:0] sum;
  logic [15:0] mixed;

  assign accept = (seq_q == SeqIdle) && i_valid;
  assign done   = (seq_q == SeqAcc) || ((seq_q == SeqByp) && pad_q);

  // Per-sample decision; the resulting mode/length/pointers are only committed when the
  // sample completes, so o_mode/o_loop_len move together with its o_valid.
  always_comb begin
    op_d       = OpByp;
    addr_d     = '0;
    mode_nxt_d = mode_q;
    len_nxt_d  = len_q;
    wr_nxt_d   = wr_q;
    rd_nxt_d   = rd_q;
    case (mode_q)
      ModeEmpty: begin
        if (i_rec) begin
          op_d       = OpWr;
          wr_nxt_d   = 20'd1;
          len_nxt_d  = 20'd1;
          rd_nxt_d   = '0;
          mode_nxt_d = (MAX_LEN == 20'd1) ? ModeLoop : ModeRecord;
        end
      end
      ModeRecord: begin
        if (i_rec) begin
          op_d      = OpWr;
          addr_d    = wr_q;
          wr_nxt_d  = wr_q + 20'd1;
          len_nxt_d = len_q + 20'd1;
          if (wr_q == MAX_LEN - 20'd1) mode_nxt_d = ModeLoop;
        end else if (i_play && (len_q != '0)) begin
          mode_nxt_d = ModeLoop;
          op_d       = OpRd;
          addr_d     = rd_q;
          rd_nxt_d   = (rd_q == len_q - 20'd1) ? '0 : rd_q + 20'd1;
        end else begin
          mode_nxt_d = ModeEmpty;
          len_nxt_d  = '0;
          wr_nxt_d   = '0;
          rd_nxt_d   = '0;
        end
      end
      ModeLoop: begin
        if (i_play) begin
          op_d     = OpRd;
          addr_d   = rd_q;
          rd_nxt_d = (rd_q == len_q - 20'd1) ? '0 : rd_q + 20'd1;
        end else begin
          mode_nxt_d = ModeEmpty;
          len_nxt_d  = '0;
          rd_nxt_d   = '0;
        end
      end
      default: begin
        mode_nxt_d = ModeEmpty;
        len_nxt_d  = '0;
        wr_nxt_d   = '0;
        rd_nxt_d   = '0;
      end
    endcase
  end

  always_comb begin
    seq_d = seq_q;
    pad_d = 1'b0;
    case (seq_q)
      SeqIdle: if (i_valid) seq_d = (op_d == OpByp) ? SeqByp : SeqReq;
      SeqReq:  if (i_sram_gnt) seq_d = SeqAcc;
      SeqAcc:  seq_d = SeqIdle;
      SeqByp: begin
        // Two cycles in bypass keep EMPTY latency equal to the SRAM path.
        pad_d = !pad_q;
        if (pad_q) seq_d = SeqIdle;
      end
      default: seq_d = SeqIdle;
    endcase
  end

  assign sum   = {samp_q[15], samp_q} + {i_sram_rdata[15], i_sram_rdata};
  assign mixed = (sum[16] != sum[15]) ? (sum[16] ? 16'h8000 : 16'h7fff) : sum[15:0];

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq_q      <= SeqIdle;
      pad_q      <= 1'b0;
      mode_q     <= ModeEmpty;
      mode_nxt_q <= ModeEmpty;
      len_q      <= '0;
      len_nxt_q  <= '0;
      wr_q       <= '0;
      wr_nxt_q   <= '0;
      rd_q       <= '0;
      rd_nxt_q   <= '0;
      addr_q     <= '0;
      op_q       <= OpByp;
      samp_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      seq_q   <= seq_d;
      pad_q   <= pad_d;
      valid_q <= done;
      if (i_valid && (seq_q != SeqIdle)) overrun_q <= 1'b1;
      if (accept) begin
        samp_q     <= i_data;
        op_q       <= op_d;
        addr_q     <= addr_d;
        mode_nxt_q <= mode_nxt_d;
        len_nxt_q  <= len_nxt_d;
        wr_nxt_q   <= wr_nxt_d;
        rd_nxt_q   <= rd_nxt_d;
      end
      if (done) begin
        data_q <= (op_q == OpRd) ? mixed : samp_q;
        mode_q <= mode_nxt_q;
        len_q  <= len_nxt_q;
        wr_q   <= wr_nxt_q;
        rd_q   <= rd_nxt_q;
      end
    end
  end

  assign acc_wr       = (seq_q == SeqAcc) && (op_q == OpWr);
  assign o_sram_req   = (seq_q == SeqReq) || (seq_q == SeqAcc);
  assign o_sram_addr  = (seq_q == SeqAcc) ? BASE_ADDR + addr_q : '0;
  assign o_sram_we_n  = !acc_wr;
  assign o_sram_wdata = acc_wr ? samp_q : '0;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_mode       = mode_q;
  assign o_loop_len   = len_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_loop_recorder.sv
// Bench for loop_recorder: table of samples with expected outputs fed through a scoreboard,
// a small SRAM model, plus hand-written stall, reset and auto-stop sequences.
module tb_loop_recorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] din;
  logic        rec, play, gnt;
  logic        req, we_n, vout, ovr;
  logic [19:0] addr, len;
  logic [15:0] wdata, rdata, dout;
  logic [1:0]  mode;
  logic        req4, we_n4, vout4, ovr4;
  logic [19:0] addr4, len4;
  logic [15:0] wdata4, dout4;
  logic [1:0]  mode4;

  always #5 clk = ~clk;

  loop_recorder dut (
    .i_AUD_BCLK(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(din), .i_rec(rec),
    .i_play(play), .o_sram_req(req), .i_sram_gnt(gnt), .o_sram_addr(addr),
    .o_sram_we_n(we_n), .o_sram_wdata(wdata), .i_sram_rdata(rdata), .o_data(dout),
    .o_valid(vout), .o_mode(mode), .o_loop_len(len), .o_overrun(ovr)
  );

  loop_recorder #(.MAX_LEN(20'd4)) dut4 (
    .i_AUD_BCLK(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(din), .i_rec(rec),
    .i_play(play), .o_sram_req(req4), .i_sram_gnt(gnt), .o_sram_addr(addr4),
    .o_sram_we_n(we_n4), .o_sram_wdata(wdata4), .i_sram_rdata(16'h0000), .o_data(dout4),
    .o_valid(vout4), .o_mode(mode4), .o_loop_len(len4), .o_overrun(ovr4)
  );

  // SRAM model for the main instance; the loop region only needs a few words.
  logic [15:0] mem [0:15];
  logic [35:0] wlog[$];
  logic [19:0] rlog[$];
  assign rdata = mem[addr[3:0]];

  always @(posedge clk) begin
    if (rst_n && !we_n) begin
      mem[addr[3:0]] <= wdata;
      wlog.push_back({addr, wdata});
    end
    if (rst_n && req && we_n && (addr != 20'd0)) rlog.push_back(addr);
  end

  int cyc = 0;
  int req_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mode;
    logic [19:0] len;
    int          at;
  } exp_t;

  exp_t sbq[$];
  exp_t q4[$];
  logic chk4 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (req) req_cnt++;
    if (vout === 1'b1) begin
      if (sbq.size() == 0) check("unexpected_o_valid", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        check("o_data", dout, e.data);
        check("o_mode", mode, e.mode);
        check("o_loop_len", len, e.len);
        check("latency", cyc, e.at);
      end
    end
    if (chk4 && (vout4 === 1'b1)) begin
      if (q4.size() == 0) check("unexpected_o_valid_max4", 64'd1, 64'd0);
      else begin
        e = q4.pop_front();
        check("max4_o_data", dout4, e.data);
        check("max4_o_mode", mode4, e.mode);
        check("max4_o_loop_len", len4, e.len);
      end
    end
  end

  task automatic push_exp(input logic [15:0] d, input logic [1:0] m, input logic [19:0] l,
                          input int at);
    exp_t e;
    e.data = d; e.mode = m; e.len = l; e.at = at;
    sbq.push_back(e);
  endtask

  task automatic sample(input logic r, input logic p, input logic [15:0] d, output int k);
    @(posedge clk); #1;
    rec = r; play = p; din = d; valid = 1'b1;
    k = cyc;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic run(input logic r, input logic p, input logic [15:0] d,
                     input logic [15:0] ed, input logic [1:0] em, input logic [19:0] el);
    int k;
    sample(r, p, d, k);
    push_exp(ed, em, el, k + 3);
    repeat (31) @(posedge clk);
  endtask

  typedef struct {
    logic        rec;
    logic        play;
    logic [15:0] din;
    logic [15:0] dout;
    logic [1:0]  mode;
    logic [19:0] len;
  } vec_t;

  vec_t        tbl[22];
  logic [35:0] wexp[5];
  logic [19:0] rexp[9];

  initial begin
    int k, r0, rc;
    exp_t e4;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b0, 16'h1234, 16'h1234, 2'd0, 20'd0};
    tbl[5]  = '{1'b1, 1'b1, 16'd1,    16'd1,    2'd1, 20'd1};
    tbl[6]  = '{1'b1, 1'b1, 16'd2,    16'd2,    2'd1, 20'd2};
    tbl[7]  = '{1'b1, 1'b1, 16'd3,    16'd3,    2'd1, 20'd3};
    tbl[8]  = '{1'b0, 1'b1, 16'd100,  16'd101,  2'd2, 20'd3};
    tbl[9]  = '{1'b0, 1'b1, 16'd100,  16'd102,  2'd2, 20'd3};
    tbl[10] = '{1'b0, 1'b1, 16'd100,  16'd103,  2'd2, 20'd3};
    tbl[11] = '{1'b1, 1'b1, 16'd100,  16'd101,  2'd2, 20'd3};
    tbl[12] = '{1'b0, 1'b1, 16'd100,  16'd102,  2'd2, 20'd3};
    tbl[13] = '{1'b0, 1'b1, 16'd100,  16'd103,  2'd2, 20'd3};
    tbl[14] = '{1'b0, 1'b1, 16'd100,  16'd101,  2'd2, 20'd3};
    tbl[15] = '{1'b0, 1'b0, 16'd5,    16'd5,    2'd0, 20'd0};
    tbl[16] = '{1'b1, 1'b1, 16'h7530, 16'h7530, 2'd1, 20'd1};
    tbl[17] = '{1'b0, 1'b1, 16'h2710, 16'h7fff, 2'd2, 20'd1};
    tbl[18] = '{1'b0, 1'b0, 16'd7,    16'd7,    2'd0, 20'd0};
    tbl[19] = '{1'b1, 1'b0, 16'h8ad0, 16'h8ad0, 2'd1, 20'd1};
    tbl[20] = '{1'b0, 1'b1, 16'hd8f0, 16'h8000, 2'd2, 20'd1};
    tbl[21] = '{1'b0, 1'b0, 16'd0,    16'd0,    2'd0, 20'd0};
    wexp = '{{20'h80000, 16'd1}, {20'h80001, 16'd2}, {20'h80002, 16'd3},
             {20'h80000, 16'h7530}, {20'h80000, 16'h8ad0}};
    rexp = '{20'h80000, 20'h80001, 20'h80002, 20'h80000, 20'h80001, 20'h80002,
             20'h80000, 20'h80000, 20'h80000};

    rst_n = 1'b0; valid = 1'b0; din = '0; rec = 1'b0; play = 1'b0; gnt = 1'b1;
    #1;
    check("rst_o_data", dout, 0);
    check("rst_o_valid", vout, 0);
    check("rst_req", req, 0);
    check("rst_we_n", we_n, 1);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_mode", mode, 0);
    check("rst_len", len, 0);
    check("rst_overrun", ovr, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    r0 = req_cnt;
    for (int i = 0; i < 22; i++) begin
      run(tbl[i].rec, tbl[i].play, tbl[i].din, tbl[i].dout, tbl[i].mode, tbl[i].len);
      if (i == 4) check("bypass_req_cycles", req_cnt - r0, 0);
    end

    check("write_count", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) check("write_addr_data", wlog[i], wexp[i]);
    check("read_count", rlog.size(), 9);
    for (int i = 0; i < 9 && i < rlog.size(); i++) check("read_addr", rlog[i], rexp[i]);

    // Two-sample loop for the grant-stall cases.
    run(1'b1, 1'b1, 16'd11, 16'd11, 2'd1, 20'd1);
    run(1'b1, 1'b1, 16'd22, 16'd22, 2'd1, 20'd2);
    check("overrun_before_stall", ovr, 0);

    @(posedge clk); #1 gnt = 1'b0;
    sample(1'b0, 1'b1, 16'd0, k);
    push_exp(16'd11, 2'd2, 20'd2, k + 8);
    rc = 0;
    for (int j = 0; j < 7; j++) begin
      if (cyc == k + 6) gnt = 1'b1;
      if (req) rc++;
      @(posedge clk); #1;
    end
    check("stall5_req_high", rc, 7);
    check("stall5_req_dropped", req, 0);
    repeat (30) @(posedge clk);

    #1 gnt = 1'b0;
    sample(1'b0, 1'b1, 16'd0, k);
    push_exp(16'd22, 2'd2, 20'd2, k + 43);
    while (cyc < k + 31) begin @(posedge clk); #1; end
    sample(1'b0, 1'b1, 16'h5555, r0);
    while (cyc < k + 41) begin @(posedge clk); #1; end
    gnt = 1'b1;
    repeat (5) @(posedge clk);
    check("stall40_overrun", ovr, 1);
    run(1'b0, 1'b1, 16'd0, 16'd11, 2'd2, 20'd2);
    check("overrun_sticky", ovr, 1);

    // Reset landing in the write access cycle.
    run(1'b0, 1'b0, 16'h0077, 16'h0077, 2'd0, 20'd0);
    sample(1'b1, 1'b1, 16'h0099, k);
    @(posedge clk); #1;
    check("acc_we_n_low", we_n, 0);
    check("acc_req_high", req, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_we_n", we_n, 1);
    check("async_rst_req", req, 0);
    check("async_rst_addr", addr, 0);
    check("async_rst_overrun", ovr, 0);
    check("async_rst_mode", mode, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("no_valid_after_rst", sbq.size(), 0);

    // Auto-stop on the MAX_LEN=4 instance, the main instance keeps recording alongside.
    chk4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      e4.data = 16'(i); e4.mode = (i == 4) ? 2'd2 : 2'd1; e4.len = 20'(i); e4.at = 0;
      q4.push_back(e4);
      run(1'b1, 1'b1, 16'(i), 16'(i), 2'd1, 20'(i));
    end
    e4.data = 16'd9; e4.mode = 2'd0; e4.len = 20'd0;
    q4.push_back(e4);
    run(1'b0, 1'b0, 16'd9, 16'd9, 2'd0, 20'd0);

    repeat (10) @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    check("max4_scoreboard_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
